// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side keyboard emulator: key events become scancode bytes in a FIFO,
// and each byte is sent on ps2_clk/ps2_data as an 11-bit frame.
module ps2_keyboard_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned IDLE_GAP   = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [7:0]                    ev_code,
    input  logic                          ev_break,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic                          tx_done,
    output logic [7:0]                    tx_byte,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam int unsigned GW = $clog2(IDLE_GAP + 1);

    localparam logic [PW-1:0] PhaseFall = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PhaseEnd  = PW'(2 * CLK_DIV - 1);
    localparam logic [GW-1:0] GapEnd    = GW'(IDLE_GAP - 1);
    // A release needs two free slots, so accept only with at least two free.
    localparam logic [CW-1:0] ReadyMax  = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StBit, StGap} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [9:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          clk_q, clk_d;
    logic          data_q, data_d;
    logic          done_q, done_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          accept;
    logic          pop;
    logic [1:0]    n_push;
    logic [7:0]    head;

    assign ev_ready = (count_q <= ReadyMax);
    assign accept   = ev_valid && ev_ready;
    assign pop      = (state_q == StIdle) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        n_push   = 2'd0;
        if (accept) begin
            if (ev_break) begin
                mem_d[wr_ptr_q]             = 8'hF0;
                mem_d[wr_ptr_q + AW'(1)]    = ev_code;
                wr_ptr_d                    = wr_ptr_q + AW'(2);
                n_push                      = 2'd2;
            end else begin
                mem_d[wr_ptr_q]             = ev_code;
                wr_ptr_d                    = wr_ptr_q + AW'(1);
                n_push                      = 2'd1;
            end
        end
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(n_push) - CW'(pop);
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        clk_d     = clk_q;
        data_d    = data_q;
        done_d    = 1'b0;
        tx_byte_d = tx_byte_q;
        unique case (state_q)
            StIdle: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (pop) begin
                    state_d   = StBit;
                    phase_d   = '0;
                    bit_idx_d = '0;
                    byte_d    = head;
                    // Bits still to send after the start bit: data LSB first, parity, stop.
                    shift_d   = {1'b1, ~^head, head};
                    data_d    = 1'b0;
                end
            end
            StBit: begin
                phase_d = phase_q + PW'(1);
                if (phase_q == PhaseFall) begin
                    clk_d = 1'b0;
                end
                if (phase_q == PhaseEnd) begin
                    phase_d = '0;
                    clk_d   = 1'b1;
                    if (bit_idx_q == 4'd10) begin
                        state_d   = StGap;
                        gap_d     = '0;
                        data_d    = 1'b1;
                        done_d    = 1'b1;
                        tx_byte_d = byte_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        data_d    = shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GapEnd) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            bit_idx_q <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            tx_byte_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            clk_q     <= clk_d;
            data_q    <= data_d;
            done_q    <= done_d;
            tx_byte_q <= tx_byte_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ps2_clk    = clk_q;
    assign ps2_data   = data_q;
    assign tx_done    = done_q;
    assign tx_byte    = tx_byte_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx with a PS/2 receiver model sampling at ps2_clk falls.
module tb_ps2_keyboard_tx;

    localparam int CLK_DIV    = 4;
    localparam int IDLE_GAP   = 8;
    localparam int FIFO_DEPTH = 8;

    localparam logic [7:0] BP_EXP [8] = '{8'hF0, 8'h11, 8'hF0, 8'h22,
                                          8'hF0, 8'h33, 8'hF0, 8'h44};
    localparam logic [7:0] BP_CODE [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [3:0] BP_CNT [4]  = '{4'd2, 4'd3, 4'd5, 4'd7};

    logic       clk = 1'b0;
    logic       resetn;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       tx_done;
    logic [7:0] tx_byte;
    logic [3:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ps2_keyboard_tx #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_GAP   (IDLE_GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_break   (ev_break),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_byte    (tx_byte),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples 1 time unit after each edge, stimulus runs at 2.
    logic        prev_clk = 1'b1;
    int          mon_n = 0;
    logic [10:0] mon_bits;
    int          mon_fall [11];
    logic [7:0]  rx_byte_q [$];
    logic [10:0] rx_bits_q [$];
    bit          rx_ok_q [$];
    int          rx_first_q [$];
    int          done_cyc_q [$];
    logic [7:0]  done_byte_q [$];

    always begin
        @(posedge clk);
        #1;
        if (resetn !== 1'b1) begin
            mon_n = 0;
        end else begin
            if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
                mon_bits[mon_n] = ps2_data;
                mon_fall[mon_n] = cyc;
                mon_n++;
                if (mon_n == 11) begin
                    rx_bits_q.push_back(mon_bits);
                    rx_byte_q.push_back(mon_bits[8:1]);
                    rx_ok_q.push_back(mon_bits[0] == 1'b0 && mon_bits[10] == 1'b1 &&
                                      (^mon_bits[9:1]) == 1'b1);
                    rx_first_q.push_back(mon_fall[0]);
                    mon_n = 0;
                end
            end
            if (tx_done === 1'b1) begin
                done_cyc_q.push_back(cyc);
                done_byte_q.push_back(tx_byte);
            end
        end
        prev_clk = ps2_clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        rx_byte_q.delete();
        rx_bits_q.delete();
        rx_ok_q.delete();
        rx_first_q.delete();
        done_cyc_q.delete();
        done_byte_q.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cyc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (done_cyc_q.size() < n) begin
            n_err++;
            $display("FAIL wait_done: got %0d frames, want %0d", done_cyc_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic send(input logic [7:0] code, input logic brk, output int acc);
        int k = 0;
        while (ev_ready !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        if (ev_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL send_ready: ev_ready=%b want 1", ev_ready);
        end
        ev_valid = 1'b1;
        ev_code  = code;
        ev_break = brk;
        tick();
        ev_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        ev_valid = 1'b1;
        ev_code  = 8'h55;
        ev_break = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({ps2_clk, ps2_data, busy, tx_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_lines: clk,data,busy,done=%b%b%b%b want 1100",
                     ps2_clk, ps2_data, busy, tx_done);
        end
        n_vec++;
        if (fifo_count !== 4'd0 || tx_byte !== 8'h00) begin
            n_err++;
            $display("FAIL reset_regs: count=%0d byte=%h want 0 00", fifo_count, tx_byte);
        end
        ev_valid = 1'b0;
        resetn   = 1'b1;
        tick();
        n_vec++;
        if (ev_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b busy=%b count=%0d want 1 0 0",
                     ev_ready, busy, fifo_count);
        end
    endtask

    task automatic test_press();
        int acc;
        clear_mon();
        send(8'h1C, 1'b0, acc);
        n_vec++;
        if (fifo_count !== 4'd1) begin
            n_err++;
            $display("FAIL press_push: count=%0d want 1", fifo_count);
        end
        tick();
        n_vec++;
        if ({ps2_clk, ps2_data, busy} !== 3'b101 || fifo_count !== 4'd0) begin
            n_err++;
            $display("FAIL press_start: clk,data,busy=%b%b%b count=%0d want 101 0",
                     ps2_clk, ps2_data, busy, fifo_count);
        end
        wait_done(1, 200);
        n_vec++;
        if (done_cyc_q[0] !== acc + 89) begin
            n_err++;
            $display("FAIL press_done_time: got %0d want %0d", done_cyc_q[0], acc + 89);
        end
        n_vec++;
        if (done_byte_q[0] !== 8'h1C) begin
            n_err++;
            $display("FAIL press_tx_byte: got %h want 1c", done_byte_q[0]);
        end
        n_vec++;
        if (rx_bits_q[0] !== 11'h438 || rx_ok_q[0] !== 1'b1) begin
            n_err++;
            $display("FAIL press_bits: got %h ok=%b want 438 1", rx_bits_q[0], rx_ok_q[0]);
        end
        n_vec++;
        if (mon_fall[0] !== acc + 5) begin
            n_err++;
            $display("FAIL press_first_fall: got %0d want %0d", mon_fall[0], acc + 5);
        end
        for (int i = 1; i < 11; i++) begin
            n_vec++;
            if (mon_fall[i] - mon_fall[i-1] !== 8) begin
                n_err++;
                $display("FAIL press_fall_spacing[%0d]: got %0d want 8", i,
                         mon_fall[i] - mon_fall[i-1]);
            end
        end
        wait_idle(100);
    endtask

    task automatic test_release();
        int acc;
        clear_mon();
        send(8'h1C, 1'b1, acc);
        n_vec++;
        if (fifo_count !== 4'd2) begin
            n_err++;
            $display("FAIL release_push: count=%0d want 2", fifo_count);
        end
        wait_done(2, 400);
        n_vec++;
        if (done_byte_q[0] !== 8'hF0 || done_byte_q[1] !== 8'h1C) begin
            n_err++;
            $display("FAIL release_tx_bytes: got %h %h want f0 1c", done_byte_q[0],
                     done_byte_q[1]);
        end
        n_vec++;
        if (rx_byte_q[0] !== 8'hF0 || rx_byte_q[1] !== 8'h1C ||
            rx_ok_q[0] !== 1'b1 || rx_ok_q[1] !== 1'b1) begin
            n_err++;
            $display("FAIL release_rx: got %h %h ok=%b%b want f0 1c ok=11", rx_byte_q[0],
                     rx_byte_q[1], rx_ok_q[0], rx_ok_q[1]);
        end
        n_vec++;
        if (rx_bits_q[0] !== 11'h7E0) begin
            n_err++;
            $display("FAIL release_f0_bits: got %h want 7e0", rx_bits_q[0]);
        end
        n_vec++;
        if (done_cyc_q[0] !== acc + 89) begin
            n_err++;
            $display("FAIL release_done1_time: got %0d want %0d", done_cyc_q[0], acc + 89);
        end
        // Frame 2 starts 9 cycles after tx_done, so its first fall is 13 after.
        n_vec++;
        if (rx_first_q[1] !== done_cyc_q[0] + 13) begin
            n_err++;
            $display("FAIL release_gap: first fall %0d want %0d", rx_first_q[1],
                     done_cyc_q[0] + 13);
        end
        n_vec++;
        if (done_cyc_q[1] - done_cyc_q[0] !== 97) begin
            n_err++;
            $display("FAIL release_period: got %0d want 97", done_cyc_q[1] - done_cyc_q[0]);
        end
        wait_idle(100);
    endtask

    task automatic test_backpressure();
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ev_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b want 1", i, ev_ready);
            end
            ev_valid = 1'b1;
            ev_code  = BP_CODE[i];
            ev_break = 1'b1;
            tick();
            n_vec++;
            if (fifo_count !== BP_CNT[i]) begin
                n_err++;
                $display("FAIL bp_count[%0d]: got %0d want %0d", i, fifo_count, BP_CNT[i]);
            end
        end
        n_vec++;
        if (ev_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: ev_ready=%b want 0", ev_ready);
        end
        ev_code  = 8'h55;
        ev_break = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (fifo_count !== 4'd7 || ev_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ignored[%0d]: count=%0d ready=%b want 7 0", i, fifo_count,
                         ev_ready);
            end
        end
        ev_valid = 1'b0;
        wait_done(8, 1200);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (rx_byte_q[i] !== BP_EXP[i] || done_byte_q[i] !== BP_EXP[i]) begin
                n_err++;
                $display("FAIL bp_order[%0d]: rx=%h tx=%h want %h", i, rx_byte_q[i],
                         done_byte_q[i], BP_EXP[i]);
            end
        end
        wait_idle(200);
        n_vec++;
        if (done_cyc_q.size() !== 8) begin
            n_err++;
            $display("FAIL bp_total: got %0d frames want 8", done_cyc_q.size());
        end
    endtask

    task automatic test_push_pop();
        int acc;
        int k = 0;
        clear_mon();
        send(8'h2A, 1'b1, acc);
        while (tx_done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if (tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL pp_first_done: tx_done=%b want 1", tx_done);
        end
        repeat (8) tick();
        n_vec++;
        if (fifo_count !== 4'd1 || ev_ready !== 1'b1 || ps2_data !== 1'b1) begin
            n_err++;
            $display("FAIL pp_pre: count=%0d ready=%b data=%b want 1 1 1", fifo_count,
                     ev_ready, ps2_data);
        end
        ev_valid = 1'b1;
        ev_code  = 8'h3B;
        ev_break = 1'b0;
        tick();
        ev_valid = 1'b0;
        n_vec++;
        if (fifo_count !== 4'd1 || ps2_data !== 1'b0) begin
            n_err++;
            $display("FAIL pp_same_edge: count=%0d data=%b want 1 0", fifo_count, ps2_data);
        end
        wait_done(3, 500);
        n_vec++;
        if (rx_byte_q[0] !== 8'hF0 || rx_byte_q[1] !== 8'h2A || rx_byte_q[2] !== 8'h3B) begin
            n_err++;
            $display("FAIL pp_order: got %h %h %h want f0 2a 3b", rx_byte_q[0], rx_byte_q[1],
                     rx_byte_q[2]);
        end
        wait_idle(100);
    endtask

    task automatic test_reset_midframe();
        int acc;
        clear_mon();
        send(8'h66, 1'b1, acc);
        while (cyc < acc + 45) tick();
        n_vec++;
        if (ps2_data !== 1'b1 || ps2_clk !== 1'b0) begin
            n_err++;
            $display("FAIL mid_bit4: data=%b clk=%b want 1 0", ps2_data, ps2_clk);
        end
        resetn = 1'b0;
        tick();
        n_vec++;
        if ({ps2_clk, ps2_data, busy, tx_done} !== 4'b1100 || fifo_count !== 4'd0) begin
            n_err++;
            $display("FAIL mid_abort: clk,data,busy,done=%b%b%b%b count=%0d want 1100 0",
                     ps2_clk, ps2_data, busy, tx_done, fifo_count);
        end
        resetn = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (done_cyc_q.size() !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_quiet: frames=%0d busy=%b want 0 0", done_cyc_q.size(), busy);
        end
        clear_mon();
        send(8'h45, 1'b0, acc);
        wait_done(1, 200);
        n_vec++;
        if (done_byte_q[0] !== 8'h45 || rx_byte_q[0] !== 8'h45) begin
            n_err++;
            $display("FAIL mid_resume_byte: tx=%h rx=%h want 45", done_byte_q[0],
                     rx_byte_q[0]);
        end
        n_vec++;
        if (rx_bits_q[0] !== 11'h48A || rx_ok_q[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_resume_bits: got %h ok=%b want 48a 1", rx_bits_q[0],
                     rx_ok_q[0]);
        end
        wait_idle(100);
        n_vec++;
        if (done_cyc_q.size() !== 1) begin
            n_err++;
            $display("FAIL mid_resume_count: got %0d frames want 1", done_cyc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_backpressure();
        test_push_pop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
